usb_rx_bitproc: RTL and testbench

Receive bit processor for the full-speed USB device path. Per bit strobe it takes the recovered line level and an SE0 flag and performs these steps:
- NRZI decode and SYNC detection.
- Bit de-stuffing with a parametrised run length, plus stuff-error detection.
- LSB-first byte assembly.
- EOP detection, with an alignment check.

It sits between the clock/data-recovery stage and the packet/PID decoder. It supersedes the plain NRZI/destuff stage: it adds framing, error reporting and word output.

---
 rtl/usb_rx_pkg.sv | 18 +
 rtl/usb_nrzi_destuff.sv | 55 +++++
 rtl/usb_rx_bitproc.sv | 174 +++++++++++++++++
 tb/tb_usb_rx_bitproc.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared definitions for the full-speed USB receive bit path: framing states,
// line levels and default geometry.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_EOP   = 2'd2,
        ST_ERROR = 2'd3
    } rx_state_t;

    localparam logic LINE_J = 1'b1;
    localparam logic LINE_K = 1'b0;

    localparam int DEFAULT_STUFF_LEN = 6;
    localparam int DEFAULT_DATA_W    = 8;

endpackage

// File: rtl/usb_nrzi_destuff.sv
// NRZI decoder and bit de-stuffer. Decode and stuff classification are
// combinational on the current strobe; the previous level and ones run are registered.
module usb_nrzi_destuff
    import usb_rx_pkg::*;
#(
    parameter int STUFF_LEN   = DEFAULT_STUFF_LEN,
    parameter int STUFF_CHECK = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_bit,
    input  logic i_se0,
    input  logic i_bit_en,
    input  logic i_destuff_en,
    input  logic i_ones_load,
    output logic o_dec_bit,
    output logic o_keep,
    output logic o_stuff_err
);

    localparam int ONES_W = $clog2(STUFF_LEN + 1);
    localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(STUFF_LEN);
    localparam logic [ONES_W-1:0] ONES_ONE = ONES_W'(1);

    logic              r_prev;
    logic [ONES_W-1:0] r_ones;
    logic              w_is_stuff;

    assign o_dec_bit   = r_prev ~^ i_bit;
    assign w_is_stuff  = (r_ones == ONES_MAX);
    assign o_keep      = !w_is_stuff;
    assign o_stuff_err = (STUFF_CHECK != 0) && w_is_stuff && o_dec_bit;

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= LINE_J;
            r_ones <= '0;
        end else if (i_bit_en) begin
            // SE0 leaves the line idle-J, so the next J decodes as a one.
            r_prev <= i_se0 ? LINE_J : i_bit;
            if (i_ones_load) begin
                r_ones <= ONES_ONE;
            end else if (i_destuff_en && !i_se0) begin
                if (w_is_stuff || !o_dec_bit) begin
                    r_ones <= '0;
                end else begin
                    r_ones <= r_ones + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/usb_rx_bitproc.sv
// USB full-speed receive bit processor: SYNC/EOP framing, stuff-error and
// alignment reporting, LSB-first word assembly on top of NRZI/de-stuff.
module usb_rx_bitproc
    import usb_rx_pkg::*;
#(
    parameter int STUFF_LEN      = DEFAULT_STUFF_LEN,
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int SYNC_MIN_ZEROS = 5,
    parameter int STUFF_CHECK    = 1
) (
    input  logic              i_clk_48mhz,
    input  logic              i_rst_n,
    input  logic              i_bit,
    input  logic              i_se0,
    input  logic              i_bit_en,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_valid,
    output logic              o_pkt_start,
    output logic              o_pkt_end,
    output logic              o_err_stuff,
    output logic              o_err_align,
    output logic              o_active
);

    localparam int ZR_W = $clog2(SYNC_MIN_ZEROS + 1);
    localparam int BC_W = $clog2(DATA_W + 1);
    localparam logic [ZR_W-1:0] ZR_MAX  = ZR_W'(SYNC_MIN_ZEROS);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

    rx_state_t         r_state;
    rx_state_t         w_next_state;
    logic [ZR_W-1:0]   r_zero_run;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_shift_next;
    logic              r_data_valid;
    logic              r_pkt_start;
    logic              r_pkt_end;
    logic              r_err_stuff;
    logic              r_err_align;

    logic w_dec;
    logic w_keep;
    logic w_stuff_err;
    logic w_shift_en;
    logic w_word_done;
    logic w_pkt_start;
    logic w_pkt_end;
    logic w_err_stuff;
    logic w_err_align;

    usb_nrzi_destuff #(
        .STUFF_LEN   (STUFF_LEN),
        .STUFF_CHECK (STUFF_CHECK)
    ) u_nrzi_destuff (
        .i_clk        (i_clk_48mhz),
        .i_rst_n      (i_rst_n),
        .i_bit        (i_bit),
        .i_se0        (i_se0),
        .i_bit_en     (i_bit_en),
        .i_destuff_en (r_state == ST_DATA),
        .i_ones_load  (w_pkt_start),
        .o_dec_bit    (w_dec),
        .o_keep       (w_keep),
        .o_stuff_err  (w_stuff_err)
    );

    assign w_shift_next = {w_dec, r_shift[DATA_W-1:1]};

    always_ff @(posedge i_clk_48mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_shift_en   = 1'b0;
        w_word_done  = 1'b0;
        w_pkt_start  = 1'b0;
        w_pkt_end    = 1'b0;
        w_err_stuff  = 1'b0;
        w_err_align  = 1'b0;
        if (i_bit_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (!i_se0 && w_dec && (r_zero_run == ZR_MAX)) begin
                        w_pkt_start  = 1'b1;
                        w_next_state = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (i_se0) begin
                        w_pkt_end    = 1'b1;
                        w_err_align  = (r_bit_cnt != '0);
                        w_next_state = ST_EOP;
                    end else if (!w_keep) begin
                        if (w_stuff_err) begin
                            w_err_stuff  = 1'b1;
                            w_next_state = ST_ERROR;
                        end
                    end else begin
                        w_shift_en  = 1'b1;
                        w_word_done = (r_bit_cnt == BC_LAST);
                    end
                end
                ST_EOP: begin
                    if (!i_se0) begin
                        w_next_state = ST_IDLE;
                    end
                end
                ST_ERROR: begin
                    if (i_se0) begin
                        w_next_state = ST_EOP;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk_48mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_zero_run   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_pkt_start  <= 1'b0;
            r_pkt_end    <= 1'b0;
            r_err_stuff  <= 1'b0;
            r_err_align  <= 1'b0;
        end else begin
            r_data_valid <= w_word_done;
            r_pkt_start  <= w_pkt_start;
            r_pkt_end    <= w_pkt_end;
            r_err_stuff  <= w_err_stuff;
            r_err_align  <= w_err_align;
            if (i_bit_en) begin
                // Zero run only matters while hunting for SYNC.
                if ((r_state == ST_IDLE) && !i_se0 && !w_dec) begin
                    r_zero_run <= (r_zero_run == ZR_MAX) ? ZR_MAX : r_zero_run + 1'b1;
                end else begin
                    r_zero_run <= '0;
                end
                if (w_pkt_start) begin
                    r_bit_cnt <= '0;
                end else if (w_shift_en) begin
                    r_shift <= w_shift_next;
                    if (w_word_done) begin
                        r_data    <= w_shift_next;
                        r_bit_cnt <= '0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign o_data       = r_data;
    assign o_data_valid = r_data_valid;
    assign o_pkt_start  = r_pkt_start;
    assign o_pkt_end    = r_pkt_end;
    assign o_err_stuff  = r_err_stuff;
    assign o_err_align  = r_err_align;
    assign o_active     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_usb_rx_bitproc.sv
// Directed bench for usb_rx_bitproc: default geometry (instance 0) and
// STUFF_LEN=3 / DATA_W=16 (instance 1) driven from NRZI-encoded bit streams.
module tb_usb_rx_bitproc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic bit_in [2];
    logic se0_in [2];
    logic en_in  [2];

    logic [7:0]  data_a;
    logic [15:0] data_b;
    logic [15:0] cur_data [2];
    logic dv [2];
    logic ps [2];
    logic pe [2];
    logic es [2];
    logic ea [2];
    logic act [2];

    always #5 clk = ~clk;

    usb_rx_bitproc u_dut_a (
        .i_clk_48mhz  (clk),
        .i_rst_n      (rst_n),
        .i_bit        (bit_in[0]),
        .i_se0        (se0_in[0]),
        .i_bit_en     (en_in[0]),
        .o_data       (data_a),
        .o_data_valid (dv[0]),
        .o_pkt_start  (ps[0]),
        .o_pkt_end    (pe[0]),
        .o_err_stuff  (es[0]),
        .o_err_align  (ea[0]),
        .o_active     (act[0])
    );

    usb_rx_bitproc #(
        .STUFF_LEN (3),
        .DATA_W    (16)
    ) u_dut_b (
        .i_clk_48mhz  (clk),
        .i_rst_n      (rst_n),
        .i_bit        (bit_in[1]),
        .i_se0        (se0_in[1]),
        .i_bit_en     (en_in[1]),
        .o_data       (data_b),
        .o_data_valid (dv[1]),
        .o_pkt_start  (ps[1]),
        .o_pkt_end    (pe[1]),
        .o_err_stuff  (es[1]),
        .o_err_align  (ea[1]),
        .o_active     (act[1])
    );

    assign cur_data[0] = {8'h00, data_a};
    assign cur_data[1] = data_b;

    // Pulse monitor: cumulative counts per instance plus captured words.
    int n_valid [2];
    int n_start [2];
    int n_end   [2];
    int n_stuff [2];
    int n_align [2];
    int n_coll  [2];
    logic [15:0] words [2][64];

    always @(negedge clk) begin
        for (int w = 0; w < 2; w++) begin
            if (dv[w] === 1'b1) begin
                words[w][n_valid[w] % 64] <= cur_data[w];
                n_valid[w] <= n_valid[w] + 1;
            end
            if (ps[w] === 1'b1) n_start[w] <= n_start[w] + 1;
            if (pe[w] === 1'b1) n_end[w]   <= n_end[w] + 1;
            if (es[w] === 1'b1) n_stuff[w] <= n_stuff[w] + 1;
            if (ea[w] === 1'b1) n_align[w] <= n_align[w] + 1;
            if (dv[w] === 1'b1 && pe[w] === 1'b1) n_coll[w] <= n_coll[w] + 1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int s_valid [2];
    int s_start [2];
    int s_end   [2];
    int s_stuff [2];
    int s_align [2];

    task automatic snap(input int w);
        s_valid[w] = n_valid[w];
        s_start[w] = n_start[w];
        s_end[w]   = n_end[w];
        s_stuff[w] = n_stuff[w];
        s_align[w] = n_align[w];
    endtask

    task automatic check_counts(input string tag, input int w, input int e_start,
                                input int e_valid, input int e_end, input int e_stuff,
                                input int e_align);
        check({tag, ".start"}, n_start[w] - s_start[w], e_start);
        check({tag, ".valid"}, n_valid[w] - s_valid[w], e_valid);
        check({tag, ".end"},   n_end[w] - s_end[w], e_end);
        check({tag, ".stuff"}, n_stuff[w] - s_stuff[w], e_stuff);
        check({tag, ".align"}, n_align[w] - s_align[w], e_align);
    endtask

    task automatic check_word(input string tag, input int w, input int k, input logic [15:0] exp);
        check(tag, words[w][(s_valid[w] + k) % 64], exp);
    endtask

    // Line-side encoder state.
    logic lvl     [2];
    int   ones_tx [2];
    logic corrupt [2];
    int   stuff_len [2];

    task automatic strobe(input int w, input logic b, input logic s);
        @(negedge clk);
        bit_in[w] = b;
        se0_in[w] = s;
        en_in[w]  = 1'b1;
        @(negedge clk);
        en_in[w]  = 1'b0;
    endtask

    task automatic send_dec(input int w, input logic d);
        if (!d) lvl[w] = ~lvl[w];
        strobe(w, lvl[w], 1'b0);
    endtask

    // Drive K on the data line during SE0 so SE0 priority is exercised.
    task automatic send_se0(input int w);
        lvl[w] = 1'b1;
        strobe(w, 1'b0, 1'b1);
    endtask

    task automatic send_sync(input int w, input int zeros);
        repeat (zeros) send_dec(w, 1'b0);
        send_dec(w, 1'b1);
        ones_tx[w] = 1;
    endtask

    task automatic send_data_bit(input int w, input logic d);
        send_dec(w, d);
        ones_tx[w] = d ? ones_tx[w] + 1 : 0;
        if (ones_tx[w] == stuff_len[w]) begin
            send_dec(w, corrupt[w]);
            corrupt[w] = 1'b0;
            ones_tx[w] = 0;
        end
    endtask

    task automatic send_word(input int w, input logic [15:0] v, input int nbits);
        for (int i = 0; i < nbits; i++) send_data_bit(w, v[i]);
    endtask

    task automatic send_eop(input int w);
        send_se0(w);
        send_se0(w);
        send_dec(w, 1'b1);
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        for (int w = 0; w < 2; w++) begin
            bit_in[w]  = 1'b1;
            se0_in[w]  = 1'b0;
            en_in[w]   = 1'b0;
            lvl[w]     = 1'b1;
            ones_tx[w] = 0;
            corrupt[w] = 1'b0;
        end
        stuff_len[0] = 6;
        stuff_len[1] = 3;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst.data", {24'h0, data_a}, 32'h0);
        check("rst.active", act[0], 1'b0);
        check("rst.pulses", {dv[0], ps[0], pe[0], es[0], ea[0]}, 5'b0);
        rst_n = 1'b1;

        // 1: idle J, full SYNC, 0xA5, EOP
        snap(0);
        repeat (3) send_dec(0, 1'b1);
        send_sync(0, 7);
        #1;
        check("s1.active_after_sync", act[0], 1'b1);
        send_word(0, 16'h00A5, 8);
        send_eop(0);
        settle();
        check_counts("s1", 0, 1, 1, 1, 0, 0);
        check_word("s1.word", 0, 0, 16'h00A5);
        check("s1.active_after_j", act[0], 1'b0);

        // 2: truncated SYNC of exactly five zeros, then 0x3C
        snap(0);
        send_sync(0, 5);
        send_word(0, 16'h003C, 8);
        send_eop(0);
        settle();
        check_counts("s2", 0, 1, 1, 1, 0, 0);
        check_word("s2.word", 0, 0, 16'h003C);

        // 2b: four zeros is one short of SYNC
        snap(0);
        repeat (2) send_dec(0, 1'b1);
        send_sync(0, 4);
        repeat (4) send_dec(0, 1'b1);
        settle();
        check("s2b.start", n_start[0] - s_start[0], 0);
        check("s2b.active", act[0], 1'b0);

        // 3: 0xFF forces a stuff bit after the fifth data bit, then 0x01
        snap(0);
        send_sync(0, 7);
        send_word(0, 16'h00FF, 8);
        send_word(0, 16'h0001, 8);
        send_eop(0);
        settle();
        check_counts("s3", 0, 1, 2, 1, 0, 0);
        check_word("s3.word0", 0, 0, 16'h00FF);
        check_word("s3.word1", 0, 1, 16'h0001);

        // 4: same stream with the stuff bit replaced by a one
        snap(0);
        corrupt[0] = 1'b1;
        send_sync(0, 7);
        send_word(0, 16'h00FF, 8);
        send_word(0, 16'h0001, 8);
        #1;
        check("s4.active_in_error", act[0], 1'b1);
        send_eop(0);
        settle();
        check_counts("s4", 0, 1, 0, 0, 1, 0);
        check("s4.active_after_j", act[0], 1'b0);

        // 5: 0x5A plus three stray bits before SE0
        snap(0);
        send_sync(0, 7);
        send_word(0, 16'h005A, 8);
        send_word(0, 16'h0005, 3);
        send_eop(0);
        settle();
        check_counts("s5", 0, 1, 1, 1, 0, 1);
        check_word("s5.word", 0, 0, 16'h005A);

        // 6: reset mid-byte, then a clean packet
        snap(0);
        send_sync(0, 7);
        send_word(0, 16'h0005, 3);
        #1;
        check("s6.active_before_rst", act[0], 1'b1);
        check("s6.data_held", {24'h0, data_a}, 32'h5A);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6.rst_data", {24'h0, data_a}, 32'h0);
        check("s6.rst_active", act[0], 1'b0);
        check("s6.rst_pulses", {dv[0], ps[0], pe[0], es[0], ea[0]}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;
        lvl[0] = 1'b1;
        repeat (3) send_dec(0, 1'b1);
        send_sync(0, 7);
        send_word(0, 16'h00A5, 8);
        send_eop(0);
        settle();
        check_counts("s6", 0, 2, 1, 1, 0, 0);
        check_word("s6.word", 0, 0, 16'h00A5);
        check("s6.active_after_j", act[0], 1'b0);

        // Instance 1 (STUFF_LEN=3, DATA_W=16): scenario 1
        snap(1);
        repeat (3) send_dec(1, 1'b1);
        send_sync(1, 7);
        send_word(1, 16'h5AA5, 16);
        send_eop(1);
        settle();
        check_counts("b1", 1, 1, 1, 1, 0, 0);
        check_word("b1.word", 1, 0, 16'h5AA5);
        check("b1.active_after_j", act[1], 1'b0);

        // Instance 1: scenario 3 with frequent stuffing across the word boundary
        snap(1);
        send_sync(1, 7);
        send_word(1, 16'hFFFF, 16);
        send_word(1, 16'h0001, 16);
        send_eop(1);
        settle();
        check_counts("b3", 1, 1, 2, 1, 0, 0);
        check_word("b3.word0", 1, 0, 16'hFFFF);
        check_word("b3.word1", 1, 1, 16'h0001);

        check("a.valid_with_end", n_coll[0], 0);
        check("b.valid_with_end", n_coll[1], 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
